key_unschedule: RTL and testbench
=================================

KEY_UNSCHEDULE -- requirements
Module: key_unschedule

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request to begin unscheduling key_last.
REQ-004 SHALL have port key_last, input, 128 bits: AES-128 round-10 key; byte 0 in [7:0], word 0 in [31:0], word 3 in [127:96].
REQ-005 SHALL have port busy, output, 1 bit: high from accepted start until final beat accepted.
REQ-006 SHALL have port rk_valid, output, 1 bit: round_key/round_num hold a valid beat.
REQ-007 SHALL have port rk_ready, input, 1 bit: consumer accepts the beat when rk_valid && rk_ready.
REQ-008 SHALL have port round_key, output, 128 bits: round key, same byte/word order as key_last.
REQ-009 SHALL have port round_num, output, 4 bits: round index of round_key (10..0).
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse after round-0 beat accepted.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (busy=0, rk_valid=0) and EMIT (busy=1, rk_valid=1).
REQ-012 IDLE -> EMIT on the edge where start=1; start SHALL be ignored in EMIT.
REQ-013 Inverse step SHALL be: p3=n3^n2; p2=n2^n1; p1=n1^n0; p0=n0^SubWord(RotWord(p3))^{24'h0,rcon}.
REQ-014 RotWord/SubWord SHALL apply the existing sbox module: result byte0=S(p3 byte1), byte1=S(byte2), byte2=S(byte3), byte3=S(byte0); four sbox instances, combinational.
REQ-015 rcon register SHALL hold the constant of the current round r (r=10:0x36 ... r=1:0x01); stepping down SHALL use GF inverse-xtime: rcon[0]=0 -> rcon>>1; rcon[0]=1 -> ((rcon^0x1b)>>1)|0x80 (0x36->0x1b->0x80->0x40->...->0x01).
REQ-016 On each accepted beat with round_num>0: round_key <= inverse step of round_key using rcon; round_num decrements by 1; rcon steps down; rk_valid stays 1.
REQ-017 While rk_valid && !rk_ready, round_key, round_num and rk_valid SHALL hold stable.
REQ-018 Accepted beat with round_num=0: next edge SHALL go to IDLE, rk_valid=0, busy=0, done=1 for exactly one cycle.
REQ-019 Throughput SHALL be one round key per clock with rk_ready held high; no bubbles between beats.
REQ-020 start in the same cycle done is high SHALL be accepted (IDLE entered on that edge, so start is sampled in IDLE the following cycle; no start is lost if held).

Reset
REQ-021 rst=1 at a clock edge SHALL force IDLE, busy=0, rk_valid=0, done=0, round_num=0, round_key=0, rcon=0x36, regardless of state.
REQ-022 rst during EMIT SHALL abort the sequence without a done pulse; rst dominates start in the same cycle.

Configuration
REQ-023 Macro KEY_UNSCHED_LAST_EMIT_EN SHALL select whether key_last is emitted as a beat.
REQ-024 Defined: start edge loads round_key=key_last, round_num=10, rcon=0x36; rk_valid at start+1; 11 beats (10..0).
REQ-025 Undefined: start edge loads round_key=inverse step of key_last with rcon 0x36, round_num=9, rcon=0x1b; rk_valid at start+1; 10 beats (9..0).

Verification
REQ-026 FIPS-197 vector, rk_ready=1: key_last=0xa60c63b6c80c3fe18925eec9a8f914d0 -> round 9 beat = 0x6e005c574129d12821dcfa19f36677ac, round 0 beat = 0x3c4fcf098815f7aba6d2ae2816157e2b, done 1 cycle after the round-0 beat.
REQ-027 Same vector, rk_ready toggled 1,0,0,1 pseudo-randomly -> identical beat sequence, no beat dropped or duplicated, outputs stable while stalled.
REQ-028 With KEY_UNSCHED_LAST_EMIT_EN defined -> first beat round_num=10 equals key_last, 11 beats total; undefined -> first round_num=9, 10 beats total.
REQ-029 rst asserted after round 5 beat accepted -> next cycle rk_valid=0, busy=0, round_key=0, no done; new start then yields full correct sequence from round 9 (or 10).
REQ-030 start pulsed while busy (round 7) -> ignored, sequence unaffected; start held high across done -> second sequence begins with correct first beat, rcon restarted at 0x36.

Source files
------------

// File: rtl/key_unschedule.sv
// ============================================================================
// key_unschedule
// ----------------------------------------------------------------------------
// Walks the AES-128 key schedule backwards. It starts from the round-10 key
// and emits one round key per beat on a valid/ready stream, ending at the
// original cipher key (round 0).
//
// Ports (key_unschedule):
//   clk        in   1   rising-edge clock for all state
//   rst        in   1   synchronous, active-high reset
//   start      in   1   begin unscheduling key_last (ignored while busy)
//   key_last   in 128   round-10 key; byte 0 in [7:0], word 0 in [31:0]
//   busy       out  1   high from accepted start until final beat accepted
//   rk_valid   out  1   round_key/round_num carry a valid beat
//   rk_ready   in   1   consumer accepts the beat when rk_valid && rk_ready
//   round_key  out 128  round key, same byte/word order as key_last
//   round_num  out  4   round index of round_key (10..0)
//   done       out  1   one-cycle pulse after the round-0 beat is accepted
//
// Configuration macro: KEY_UNSCHED_LAST_EMIT_EN
//   defined   -> key_last itself is emitted first as round 10 (11 beats)
//   undefined -> first beat is round 9 (10 beats)
//
// Also contains the sbox module (AES forward S-box, combinational).
// ============================================================================

// ----------------------------------------------------------------------------
// sbox: AES forward S-box.
//   in_i   in  8   input byte
//   out_o  out 8   S(in_i)
// The S-box is computed as the GF(2^8) multiplicative inverse (x^254) followed
// by the affine transform. This keeps the source compact and avoids a
// 256-entry table. Zero maps to zero under x^254, which gives S(0)=0x63.
// ----------------------------------------------------------------------------
module sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128, built by repeated squaring
    function automatic logic [7:0] gfInv(input logic [7:0] a);
        logic [7:0] pw;
        logic [7:0] acc;
        pw  = gfMul(a, a);
        acc = pw;
        for (int k = 2; k < 8; k++) begin
            pw  = gfMul(pw, pw);
            acc = gfMul(acc, pw);
        end
        return acc;
    endfunction

    logic [7:0] inv;

    assign inv   = gfInv(in_i);
    assign out_o = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;

endmodule

module key_unschedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_last,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         done
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t       state_q;
    logic [127:0] roundKey_q;
    logic [3:0]   roundNum_q;
    logic [7:0]   rcon_q;
    logic         busy_q;
    logic         rkValid_q;
    logic         done_q;

    logic [127:0] stepSrc;
    logic [31:0]  p3;
    logic [31:0]  subRot;
    logic [127:0] stepKey_d;
    logic [7:0]   rconDown_d;

    // Source of the inverse step. Without the last-key beat, the first beat
    // is already one step below key_last, so key_last feeds the step logic
    // while idle. In every other case the step works on the current beat.
`ifdef KEY_UNSCHED_LAST_EMIT_EN
    assign stepSrc = roundKey_q;
`else
    assign stepSrc = (state_q == IDLE) ? key_last : roundKey_q;
`endif

    // The previous word 3 is needed before it can be fed to RotWord/SubWord.
    assign p3 = stepSrc[127:96] ^ stepSrc[95:64];

    // RotWord followed by SubWord: output byte k = S(p3 byte k+1 mod 4)
    sbox uSbox0 (.in_i(p3[15:8]),  .out_o(subRot[7:0]));
    sbox uSbox1 (.in_i(p3[23:16]), .out_o(subRot[15:8]));
    sbox uSbox2 (.in_i(p3[31:24]), .out_o(subRot[23:16]));
    sbox uSbox3 (.in_i(p3[7:0]),   .out_o(subRot[31:24]));

    // Undo one forward key-expansion round:
    // p3=n3^n2, p2=n2^n1, p1=n1^n0, p0=n0^SubWord(RotWord(p3))^rcon
    assign stepKey_d = {
        p3,
        stepSrc[95:64] ^ stepSrc[63:32],
        stepSrc[63:32] ^ stepSrc[31:0],
        stepSrc[31:0] ^ subRot ^ {24'h0, rcon_q}
    };

    // Inverse xtime in GF(2^8): 0x36 -> 0x1b -> 0x80 -> 0x40 -> ... -> 0x01
    assign rconDown_d = rcon_q[0] ? (((rcon_q ^ 8'h1b) >> 1) | 8'h80)
                                  : (rcon_q >> 1);

    // Single FSM process. In EMIT rk_valid is always high, so rk_ready alone
    // decides acceptance. rcon is re-armed to 0x36 whenever the machine goes
    // idle, so the undefined-macro build can step key_last directly on start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            roundKey_q <= '0;
            roundNum_q <= 4'd0;
            rcon_q     <= 8'h36;
            busy_q     <= 1'b0;
            rkValid_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= EMIT;
                        busy_q    <= 1'b1;
                        rkValid_q <= 1'b1;
`ifdef KEY_UNSCHED_LAST_EMIT_EN
                        roundKey_q <= key_last;
                        roundNum_q <= 4'd10;
                        rcon_q     <= 8'h36;
`else
                        roundKey_q <= stepKey_d;
                        roundNum_q <= 4'd9;
                        rcon_q     <= rconDown_d;
`endif
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (roundNum_q == 4'd0) begin
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            rkValid_q <= 1'b0;
                            done_q    <= 1'b1;
                            rcon_q    <= 8'h36;
                        end else begin
                            roundKey_q <= stepKey_d;
                            roundNum_q <= roundNum_q - 4'd1;
                            rcon_q     <= rconDown_d;
                        end
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign rk_valid  = rkValid_q;
    assign round_key = roundKey_q;
    assign round_num = roundNum_q;
    assign done      = done_q;

endmodule

// File: tb/tb_key_unschedule.sv
// ============================================================================
// tb_key_unschedule
// ----------------------------------------------------------------------------
// Self-checking bench for key_unschedule. The reference model runs the AES-128
// key expansion forwards from a round-0 key and stores all eleven round keys.
// The DUT is fed round key 10 and must return them in reverse order. The
// S-box table for the model is generated with the generator-3 log/antilog
// walk, which is independent of the DUT's S-box construction.
// ============================================================================
module tb_key_unschedule;

`ifdef KEY_UNSCHED_LAST_EMIT_EN
    localparam int FIRST_ROUND = 10;
`else
    localparam int FIRST_ROUND = 9;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_last;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sboxTab   [0:255];
    logic [127:0] modelKeys [0:10];
    logic [127:0] seenKey   [0:10];
    int           seenCount;
    int           lastCycles;

    typedef struct {
        int           stallPct;
        int           rnd;
        logic [127:0] expKey;
    } vec_t;

    vec_t fipsVec [0:3];

    key_unschedule dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_last  (key_last),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .round_num (round_num),
        .done      (done)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Count one comparison and report it if it fails
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Build the forward S-box by walking p over powers of 3 and q over powers of 1/3
    task automatic buildSbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'b0000};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sboxTab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sboxTab[0] = 8'h63;
    endtask

    // Forward AES-128 key expansion; modelKeys[r] is the round-r key
    task automatic buildSchedule(input logic [127:0] key0);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key0[32*i +: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sboxTab[t[7:0]], sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]]}
                     ^ {24'h0, rc};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) modelKeys[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endtask

    // Drive a start pulse (or hold it) and confirm the first beat appears next cycle
    task automatic applyStimulus(input logic [127:0] kl, input bit holdStart);
        key_last = kl;
        start    = 1'b1;
        @(negedge clk);
        if (!holdStart) start = 1'b0;
        checkOutput("valid after start", rk_valid, 1);
        checkOutput("busy after start", busy, 1);
    endtask

    // Consume beats with random back-pressure until round 0 is accepted.
    // pokeRound >= 0 pulses start while that round is presented.
    task automatic collectBeats(input int stallPct, input int pokeRound);
        int           expRound;
        int           cycles;
        bit           stalled;
        logic [127:0] prevKey;
        logic [3:0]   prevNum;
        expRound  = FIRST_ROUND;
        cycles    = 0;
        stalled   = 1'b0;
        prevKey   = '0;
        prevNum   = '0;
        seenCount = 0;
        while (expRound >= 0 && cycles < 400) begin
            if (rk_valid !== 1'b1) begin
                checkOutput("valid during sequence", rk_valid, 1);
                break;
            end
            checkOutput("busy during sequence", busy, 1);
            checkOutput("no early done", done, 0);
            if (stalled) begin
                checkOutput("stall key hold", round_key, prevKey);
                checkOutput("stall num hold", round_num, prevNum);
            end
            if (pokeRound >= 0) start = (int'(round_num) == pokeRound);
            rk_ready = (int'($urandom_range(0, 99)) >= stallPct);
            if (rk_ready) begin
                checkOutput("beat round", round_num, expRound);
                checkOutput($sformatf("beat key r%0d", expRound), round_key, modelKeys[expRound]);
                seenKey[expRound] = round_key;
                seenCount++;
                expRound--;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                prevKey = round_key;
                prevNum = round_num;
            end
            @(negedge clk);
            cycles++;
        end
        if (pokeRound >= 0) start = 1'b0;
        rk_ready   = 1'b0;
        lastCycles = cycles;
        if (expRound >= 0) checkOutput("sequence completion", 128'(expRound + 1), 0);
    endtask

    // Checks the cycle right after the round-0 beat is accepted
    task automatic finishSeq(input bit heldStart);
        checkOutput("done pulse", done, 1);
        checkOutput("valid after last", rk_valid, 0);
        checkOutput("busy after last", busy, 0);
        checkOutput("beat count", seenCount, FIRST_ROUND + 1);
        if (!heldStart) begin
            @(negedge clk);
            checkOutput("done width", done, 0);
            checkOutput("stays idle", rk_valid, 0);
        end
    endtask

    initial begin
        logic [127:0] fipsKey0;
        logic [127:0] fipsLast;
        logic [127:0] k0;
        logic [127:0] k1Last;

        fipsKey0 = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
        fipsLast = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
        fipsVec[0] = '{stallPct: 0,  rnd: 9, expKey: 128'h6e005c574129d12821dcfa19f36677ac};
        fipsVec[1] = '{stallPct: 0,  rnd: 0, expKey: 128'h3c4fcf098815f7aba6d2ae2816157e2b};
        fipsVec[2] = '{stallPct: 50, rnd: 1, expKey: 128'h05766c2a3939a323b12c548817fefaa0};
        fipsVec[3] = '{stallPct: 60, rnd: 9, expKey: 128'h6e005c574129d12821dcfa19f36677ac};

        buildSbox();

        rst      = 1'b1;
        start    = 1'b0;
        rk_ready = 1'b0;
        key_last = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset valid", rk_valid, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset round_num", round_num, 0);
        checkOutput("reset round_key", round_key, 0);
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 vector under several back-pressure levels
        buildSchedule(fipsKey0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(fipsLast, 1'b0);
            collectBeats(fipsVec[i].stallPct, -1);
            if (fipsVec[i].stallPct == 0) checkOutput("no bubbles", lastCycles, FIRST_ROUND + 1);
            finishSeq(1'b0);
            checkOutput($sformatf("fips r%0d", fipsVec[i].rnd), seenKey[fipsVec[i].rnd], fipsVec[i].expKey);
        end

        // start pulsed while round 7 is presented must be ignored
        applyStimulus(fipsLast, 1'b0);
        collectBeats(0, 7);
        finishSeq(1'b0);

        // start held across done: second sequence begins automatically
        k0 = {$urandom, $urandom, $urandom, $urandom};
        buildSchedule(k0);
        applyStimulus(modelKeys[10], 1'b1);
        collectBeats(30, -1);
        finishSeq(1'b1);
        k0 = {$urandom, $urandom, $urandom, $urandom};
        buildSchedule(k0);
        key_last = modelKeys[10];
        @(negedge clk);
        start = 1'b0;
        checkOutput("restart valid", rk_valid, 1);
        checkOutput("restart round", round_num, FIRST_ROUND);
        collectBeats(20, -1);
        finishSeq(1'b0);

        // Reset after the round-5 beat aborts without done; rst beats start
        k0 = {$urandom, $urandom, $urandom, $urandom};
        buildSchedule(k0);
        k1Last = modelKeys[10];
        applyStimulus(k1Last, 1'b0);
        rk_ready = 1'b1;
        repeat (FIRST_ROUND - 4) @(negedge clk);
        checkOutput("pre-abort round", round_num, 4);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b0;
        checkOutput("abort valid", rk_valid, 0);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort key", round_key, 0);
        checkOutput("abort round_num", round_num, 0);
        checkOutput("abort done", done, 0);
        @(negedge clk);
        checkOutput("abort no done", done, 0);
        checkOutput("abort stays idle", rk_valid, 0);
        applyStimulus(k1Last, 1'b0);
        collectBeats(25, -1);
        finishSeq(1'b0);

        // Random keys with random back-pressure
        for (int n = 0; n < 4; n++) begin
            k0 = {$urandom, $urandom, $urandom, $urandom};
            buildSchedule(k0);
            applyStimulus(modelKeys[10], 1'b0);
            collectBeats(int'($urandom_range(0, 60)), -1);
            finishSeq(1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
